muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in operand width.
- Sits beside the combinational alu in the execute stage. The core issues M-extension ops through a valid/ready handshake and stalls until the result returns.
- Executes one radix-2 step per cycle, with a sign fix-up cycle and fast paths for divide-by-zero and signed overflow.

---
 rtl/muldiv_unit_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 op codes,
// FSM state encodings and the radix-2 step mode.
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_e;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: LSB-first shift-add for multiply,
// MSB-first restoring shift-subtract for divide.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  step_mode_e        mode,
    input  logic [XLEN-1:0]   acc,
    input  logic [XLEN-1:0]   shreg,
    input  logic [XLEN-1:0]   operand,
    output logic [XLEN-1:0]   acc_next,
    output logic [XLEN-1:0]   shreg_next
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] rem_shift_s;
    logic [XLEN:0] diff_s;

    // Single step; for divide the partial remainder never exceeds XLEN bits.
    always_comb begin
        sum_s       = {1'b0, acc};
        rem_shift_s = {acc, shreg[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, operand};
        acc_next    = '0;
        shreg_next  = '0;
        if (mode == MODE_MUL) begin
            if (shreg[0]) begin
                sum_s = {1'b0, acc} + {1'b0, operand};
            end else begin
                sum_s = {1'b0, acc};
            end
            acc_next   = sum_s[XLEN:1];
            shreg_next = {sum_s[0], shreg[XLEN-1:1]};
        end else begin
            if (!diff_s[XLEN]) begin
                acc_next   = diff_s[XLEN-1:0];
                shreg_next = {shreg[XLEN-2:0], 1'b1};
            end else begin
                acc_next   = rem_shift_s[XLEN-1:0];
                shreg_next = {shreg[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude iteration over XLEN cycles,
// one sign fix-up cycle, and single-cycle fast paths for div-by-zero/overflow.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       op_r;
    logic [XLEN-1:0]  acc_r;
    logic [XLEN-1:0]  shreg_r;
    logic [XLEN-1:0]  opnd_r;
    logic             neg_r;
    logic [XLEN-1:0]  out_r;
    logic             out_valid_r;

    logic             a_signed_s;
    logic             b_signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [XLEN-1:0]  a_mag_s;
    logic [XLEN-1:0]  b_mag_s;
    logic             neg_s;
    logic             b_zero_s;
    logic             fast_s;
    logic [XLEN-1:0]  fast_res_s;
    step_mode_e       mode_s;
    logic [XLEN-1:0]  step_acc_s;
    logic [XLEN-1:0]  step_shreg_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]  quo_fix_s;
    logic [XLEN-1:0]  rem_fix_s;
    logic [XLEN-1:0]  result_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign out       = out_r;

    // Operand decode at accept: signedness, magnitudes, result sign, fast path.
    always_comb begin
        a_signed_s = (op_code != OP_MULHU) && (op_code != OP_DIVU) && (op_code != OP_REMU);
        b_signed_s = (op_code == OP_MUL) || (op_code == OP_MULH) ||
                     (op_code == OP_DIV) || (op_code == OP_REM);
        a_neg_s    = a_signed_s && in_a[XLEN-1];
        b_neg_s    = b_signed_s && in_b[XLEN-1];
        a_mag_s    = a_neg_s ? (-in_a) : in_a;
        b_mag_s    = b_neg_s ? (-in_b) : in_b;
        // The remainder follows the dividend; everything else follows a^b.
        if ((op_code == OP_REM) || (op_code == OP_REMU)) begin
            neg_s = a_neg_s;
        end else begin
            neg_s = a_neg_s ^ b_neg_s;
        end
        b_zero_s = (in_b == '0);
        fast_s   = is_div_op(op_code) &&
                   (b_zero_s || (((op_code == OP_DIV) || (op_code == OP_REM)) &&
                                 (in_a == MIN_VAL) && (in_b == '1)));
        case (op_code)
            OP_DIV, OP_DIVU: fast_res_s = b_zero_s ? '1 : MIN_VAL;
            OP_REM, OP_REMU: fast_res_s = b_zero_s ? in_a : '0;
            default:         fast_res_s = '0;
        endcase
    end

    assign mode_s = is_div_op(op_r) ? MODE_DIV : MODE_MUL;

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode       (mode_s),
        .acc        (acc_r),
        .shreg      (shreg_r),
        .operand    (opnd_r),
        .acc_next   (step_acc_s),
        .shreg_next (step_shreg_s)
    );

    // Sign fix-up and result selection used in the FIX cycle.
    always_comb begin
        prod_fix_s = neg_r ? (-{acc_r, shreg_r}) : {acc_r, shreg_r};
        quo_fix_s  = neg_r ? (-shreg_r) : shreg_r;
        rem_fix_s  = neg_r ? (-acc_r) : acc_r;
        case (op_r)
            OP_MUL:                       result_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result_s = quo_fix_s;
            OP_REM, OP_REMU:              result_s = rem_fix_s;
            default:                      result_s = '0;
        endcase
    end

    // Control FSM and datapath registers; flush overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 3'd0;
            acc_r       <= '0;
            shreg_r     <= '0;
            opnd_r      <= '0;
            neg_r       <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r    <= op_code;
                        acc_r   <= '0;
                        shreg_r <= a_mag_s;
                        opnd_r  <= b_mag_s;
                        neg_r   <= neg_s;
                        cnt_r   <= '0;
                        if (fast_s) begin
                            out_r       <= fast_res_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_r   <= step_acc_s;
                    shreg_r <= step_shreg_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN - 1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    out_r       <= result_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed results, latency,
// backpressure, flush and asynchronous reset checks.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op_code;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;

    int n_checks;
    int n_fail;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1; cycle k = k-th sample (#1 after edge) after the accept edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        logic busy_ok;
        @(negedge clk);
        op_code   = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, "_rdy_before"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && cyc < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (in_ready) busy_ok = 1'b0;
        check_eq({tag, "_lat"}, 64'(cyc), 64'(lat));
        check_eq({tag, "_out"}, 64'(out), 64'(exp));
        check_eq({tag, "_busy"}, 64'(busy_ok), 64'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_after"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        int cyc;
        logic stable_ok;
        logic [31:0] hold;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op_code   = 3'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        #12;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_out", 64'(out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7_m3",   OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("mulh_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu_max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu_m1",  OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        run_op("div_m7_2",   OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem_m7_2",   OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("divu_big",   OP_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
        run_op("remu_big",   OP_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001, 34);
        run_op("div_by0",    OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_by0",    OP_REM,    32'd5,        32'd0,        32'h00000005, 1);
        run_op("div_ovf",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        op_code   = OP_DIVU;
        in_a      = 32'd100;
        in_b      = 32'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("bp_lat", 64'(cyc), 64'd34);
        check_eq("bp_out", 64'(out), 64'd14);
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out !== 32'd14) stable_ok = 1'b0;
        end
        check_eq("bp_stable", 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release", 64'({in_ready, out_valid}), 64'b10);

        // Flush at cycle 10 of a DIVU.
        @(negedge clk);
        op_code  = OP_DIVU;
        in_a     = 32'd1000;
        in_b     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc      = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        hold  = out;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_ready", 64'(in_ready), 64'd1);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_out_hold", 64'(out), 64'(hold));
        stable_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stable_ok = 1'b0;
        end
        check_eq("flush_no_result", 64'(stable_ok), 64'd1);
        run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 34);

        // Flush with in_valid in IDLE must not accept.
        @(negedge clk);
        op_code  = OP_MUL;
        in_a     = 32'd2;
        in_b     = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_idle_noaccept", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        op_code  = OP_MUL;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid_out", 64'(out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_rst", OP_MUL, 32'd6, 32'd7, 32'd42, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
